// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch controller with a 2-entry prefetch buffer
// Issues in-order word fetches, buffers {pc, instr} pairs and handles branch/jump redirects.

module fetch_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  output logic        not_empty,
  output logic        full,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr
);
  logic [1:0]  count;
  logic [31:0] pc0;
  logic [31:0] instr0;
  logic [31:0] pc1;
  logic [31:0] instr1;
  logic        pop_ok;
  logic        push_ok;

  assign not_empty = (count != 2'd0);
  assign full      = (count == 2'd2);
  assign pop_ok    = pop && not_empty;
  assign push_ok   = push && (!full || pop_ok);

  // An empty buffer reads as pc 0 / instr 0 rather than exposing stale entries.
  assign head_pc    = not_empty ? pc0 : 32'h0;
  assign head_instr = not_empty ? instr0 : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      pc0    <= 32'h0;
      instr0 <= 32'h0;
      pc1    <= 32'h0;
      instr1 <= 32'h0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
          end else begin
            pc1    <= push_pc;
            instr1 <= push_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0    <= pc1;
          instr0 <= instr1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
          end else begin
            pc0    <= pc1;
            instr0 <= instr1;
            pc1    <= push_pc;
            instr1 <= push_instr;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] next_instruct,
  output logic        instr_valid
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        push;
  logic        pop;
  logic        fifo_full;

  assign redirect        = jump | branch;
  assign redirect_target = jump ? jump_target : branch_target;

  // DRAIN keeps presenting the abandoned address so the memory sees a stable request.
  assign mem_req  = ((state == FETCH) && !fifo_full) || (state == DRAIN);
  assign mem_addr = (state == DRAIN) ? drain_addr : pc;

  assign push          = mem_req && mem_ready && (state == FETCH) && !redirect;
  assign pop           = instr_valid && !stall;
  assign next_instruct = instr_pc + 32'd4;

  fetch_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push),
    .push_pc    (pc),
    .push_instr (mem_data),
    .pop        (pop),
    .not_empty  (instr_valid),
    .full       (fifo_full),
    .head_pc    (instr_pc),
    .head_instr (instruction)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) pc <= redirect_target;
        end
        FETCH: begin
          if (redirect) begin
            pc <= redirect_target;
            if (mem_req && !mem_ready) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else if (push) begin
            pc <= pc + 32'd4;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redirect_target;
          if (mem_ready) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized bench for fetch_controller against a queue-based model
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] next_instruct;
  logic        instr_valid;

  int total = 0;
  int bad = 0;

  fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .next_instruct (next_instruct),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  // Model: the fetch pointer, an in-order queue of delivered {pc, instr}, and
  // whether an abandoned request is still owed a completion.
  logic [31:0] m_pc;
  logic [31:0] m_old;
  bit          m_idle;
  bit          m_drain;
  logic [63:0] m_q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic bit e_req();
    return !m_idle && (m_drain || (m_q.size() < 2));
  endfunction

  function automatic logic [31:0] e_addr();
    return m_drain ? m_old : m_pc;
  endfunction

  function automatic logic [31:0] e_ipc();
    logic [63:0] h;
    if (m_q.size() == 0) return 32'h0;
    h = m_q[0];
    return h[63:32];
  endfunction

  function automatic logic [31:0] e_instr();
    logic [63:0] h;
    if (m_q.size() == 0) return 32'h0;
    h = m_q[0];
    return h[31:0];
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    t[1:0] = 2'b00;
    if ($urandom_range(0, 3) == 0) t[31:8] = 24'hFF_FFFF;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_old   = 32'h0;
    m_idle  = 1'b1;
    m_drain = 1'b0;
    m_q.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_next", next_instruct, 32'h4);
    model_reset();
    stall = 1'b0; branch = 1'b0; jump = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic cyc(input bit st, input bit br, input logic [31:0] bt,
                     input bit jp, input logic [31:0] jt, input bit rdy);
    bit          req;
    bit          redir;
    bit          had;
    logic [31:0] tgt;
    @(negedge clk);
    stall = st; branch = br; branch_target = bt;
    jump = jp; jump_target = jt; mem_ready = rdy;
    req = e_req();
    mem_data = req ? memfn(e_addr()) : $urandom;
    #1;
    chk1("mem_req", mem_req, req);
    if (req) chk("mem_addr", mem_addr, e_addr());
    chk1("instr_valid", instr_valid, m_q.size() > 0);
    chk("instr_pc", instr_pc, e_ipc());
    chk("instruction", instruction, e_instr());
    chk("next_instruct", next_instruct, e_ipc() + 32'd4);

    redir = jp || br;
    tgt   = jp ? jt : bt;
    had   = m_q.size() > 0;
    if (m_idle) begin
      m_idle = 1'b0;
      if (redir) m_pc = tgt;
    end else if (redir) begin
      m_q.delete();
      if (!m_drain && req && !rdy) begin
        m_drain = 1'b1;
        m_old   = m_pc;
      end else if (m_drain && rdy) begin
        m_drain = 1'b0;
      end
      m_pc = tgt;
    end else begin
      if (had && !st) void'(m_q.pop_front());
      if (m_drain) begin
        if (rdy) m_drain = 1'b0;
      end else if (req && rdy) begin
        m_q.push_back({m_pc, memfn(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Streaming from reset
    cyc(0, 0, 0, 0, 0, 1);
    chk1("idle_req", mem_req, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stream_a0", mem_addr, 32'h0);
    chk1("stream_v0", instr_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stream_a1", mem_addr, 32'h4);
    chk("stream_pc0", instr_pc, 32'h0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stream_a2", mem_addr, 32'h8);
    chk("stream_pc1", instr_pc, 32'h4);
    chk("stream_ins1", instruction, memfn(32'h4));
    chk("stream_next1", next_instruct, 32'h8);
    repeat (6) cyc(0, 0, 0, 0, 0, 1);

    // Backpressure
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1);
    chk1("bp_req", mem_req, 1'b0);
    chk1("bp_valid", instr_valid, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp_pop0", instr_pc, 32'd32);
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp_pop1", instr_pc, 32'd36);
    chk("bp_resume", mem_addr, 32'd40);

    // Jump while the request at 0x8 sees three wait states
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h100, 0);
    chk("drain_a0", mem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_a1", mem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_a2", mem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_a3", mem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_next", mem_addr, 32'h100);
    chk1("drain_valid", instr_valid, 1'b0);

    // Redirect during the idle cycle
    do_reset();
    cyc(0, 0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk1("idle_redir_req", mem_req, 1'b1);
    chk("idle_redir_addr", mem_addr, 32'h200);

    // Jump beats branch, completing data dropped
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h40, 1, 32'h80, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk1("prio_valid", instr_valid, 1'b0);
    chk("prio_addr", mem_addr, 32'h80);

    // PC wrap
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_a0", mem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_a1", mem_addr, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_next", next_instruct, 32'h0);

    // Reset in the middle of a drain
    cyc(0, 0, 0, 1, 32'h300, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_drain_pre", mem_addr, 32'h4);
    do_reset();
    repeat (4) cyc(0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, rand_tgt(),
            $urandom_range(0, 99) < 5, rand_tgt(), $urandom_range(0, 99) < 65);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
